// File: rtl/axi_llc_pkg.sv
// axi_llc_pkg: shared LLC types for the data way and its request arbiter.
package axi_llc_pkg;
  localparam int unsigned DataWayMaxBurst = 16;
  typedef enum logic [2:0] {
    EvictUnit  = 3'd0,
    RefillUnit = 3'd1,
    ReadUnit   = 3'd2,
    WriteUnit  = 3'd3
  } cache_unit_e;
  typedef struct packed {
    cache_unit_e cache_unit;
    logic [1:0]  way_ind;
    logic [7:0]  line_addr;
    logic [1:0]  blk_offset;
    logic        we;
    logic [31:0] data;
    logic [3:0]  strb;
  } way_inp_t;
  typedef struct packed {
    cache_unit_e cache_unit;
    logic [31:0] data;
  } way_oup_t;
endpackage

// File: rtl/axi_llc_rr_lock_arb.sv
// axi_llc_rr_lock_arb: round-robin grant that locks onto a burst owner until last
// or until MaxBurst beats have passed (MaxBurst = 0 never forces release).
module axi_llc_rr_lock_arb #(
  parameter int unsigned NumReq   = 4,
  parameter int unsigned MaxBurst = 16,
  localparam int unsigned IdxW    = $clog2(NumReq),
  localparam int unsigned CntW    = (MaxBurst > 0) ? $clog2(MaxBurst + 1) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NumReq-1:0] valid_i,
  input  logic [NumReq-1:0] last_i,
  input  logic              ready_i,
  output logic [IdxW-1:0]   gnt_idx_o,
  output logic              gnt_valid_o
);
  logic            lock_q, lock_d, hs, rel, cap;
  logic [IdxW-1:0] owner_q, owner_d, rr_ptr_q, rr_ptr_d, rr_idx, nxt_ptr;
  logic [CntW-1:0] beat_cnt_q, beat_cnt_d;
  logic [IdxW:0]   cand;
  // Scan from farthest to nearest offset so the first valid at/after rr_ptr_q wins.
  always_comb begin
    rr_idx = rr_ptr_q;
    cand   = '0;
    for (int k = NumReq - 1; k >= 0; k--) begin
      cand   = {1'b0, rr_ptr_q} + (IdxW + 1)'(k);
      cand   = (cand >= (IdxW + 1)'(NumReq)) ? cand - (IdxW + 1)'(NumReq) : cand;
      rr_idx = valid_i[cand[IdxW-1:0]] ? cand[IdxW-1:0] : rr_idx;
    end
  end
  assign gnt_idx_o   = lock_q ? owner_q : rr_idx;
  assign gnt_valid_o = lock_q ? valid_i[owner_q] : |valid_i;
  assign hs          = gnt_valid_o & ready_i;
  assign cap         = (MaxBurst != 0) && (({1'b0, beat_cnt_q} + (CntW + 1)'(1)) == (CntW + 1)'(MaxBurst));
  assign rel         = last_i[gnt_idx_o] | cap;
  assign nxt_ptr     = (gnt_idx_o == IdxW'(NumReq - 1)) ? '0 : gnt_idx_o + IdxW'(1);
  always_comb begin
    lock_d     = hs ? !rel : lock_q;
    owner_d    = (hs && !rel) ? gnt_idx_o : owner_q;
    rr_ptr_d   = (hs && rel) ? nxt_ptr : rr_ptr_q;
    beat_cnt_d = !hs ? beat_cnt_q : rel ? '0 : (&beat_cnt_q ? beat_cnt_q : beat_cnt_q + CntW'(1));
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q     <= 1'b0;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      lock_q     <= lock_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end
endmodule

// File: rtl/axi_llc_data_way_arb.sv
// axi_llc_data_way_arb: shares one data way among the LLC units with burst-locked
// round-robin on requests and cache_unit-steered demux on read responses.
module axi_llc_data_way_arb
  import axi_llc_pkg::*;
#(
  parameter int unsigned NumReq   = 4,
  parameter int unsigned MaxBurst = DataWayMaxBurst,
  parameter type way_inp_t        = axi_llc_pkg::way_inp_t,
  parameter type way_oup_t        = axi_llc_pkg::way_oup_t
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  way_inp_t [NumReq-1:0]   req_i,
  input  logic [NumReq-1:0]       req_valid_i,
  input  logic [NumReq-1:0]       req_last_i,
  output logic [NumReq-1:0]       req_ready_o,
  output way_inp_t                way_o,
  output logic                    way_valid_o,
  input  logic                    way_ready_i,
  input  way_oup_t                way_rsp_i,
  input  logic                    way_rsp_valid_i,
  output logic                    way_rsp_ready_o,
  output way_oup_t                rsp_o,
  output logic [NumReq-1:0]       rsp_valid_o,
  input  logic [NumReq-1:0]       rsp_ready_i
);
  localparam int unsigned IdxW = $clog2(NumReq);
  localparam int unsigned CuW  = $bits(cache_unit_e);
  logic [IdxW-1:0] gnt_idx;
  logic [CuW-1:0]  cu;
  logic            cu_err;
  axi_llc_rr_lock_arb #(
    .NumReq   (NumReq),
    .MaxBurst (MaxBurst)
  ) i_arb (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .valid_i     (req_valid_i),
    .last_i      (req_last_i),
    .ready_i     (way_ready_i),
    .gnt_idx_o   (gnt_idx),
    .gnt_valid_o (way_valid_o)
  );
  always_comb begin
    way_o            = req_i[gnt_idx];
    way_o.cache_unit = cache_unit_e'(CuW'(gnt_idx));
  end
  assign req_ready_o = NumReq'(way_ready_i) << gnt_idx;
  // Responses for a non-existent unit are swallowed so the data way never stalls on them.
  assign cu              = way_rsp_i.cache_unit;
  assign cu_err          = 32'(cu) >= NumReq;
  assign rsp_o           = way_rsp_i;
  assign rsp_valid_o     = cu_err ? '0 : (NumReq'(way_rsp_valid_i) << cu);
  assign way_rsp_ready_o = cu_err | rsp_ready_i[cu[IdxW-1:0]];
  for (genvar i = 0; i < NumReq; i++) begin : g_req_stable
    assert property (@(posedge clk_i) disable iff (!rst_ni)
      req_valid_i[i] && !req_ready_o[i] |=> req_valid_i[i] && $stable(req_i[i]));
  end
  assert property (@(posedge clk_i) disable iff (!rst_ni) way_rsp_valid_i |-> !cu_err);
endmodule

// File: tb/tb_axi_llc_data_way_arb.sv
// tb_axi_llc_data_way_arb: directed bench with scoreboarded grant and response checks.
module tb_axi_llc_data_way_arb;
  import axi_llc_pkg::*;
  typedef struct packed {
    logic       vld;
    logic [1:0] gnt;
    logic [3:0] rdy;
  } req_exp_t;
  typedef struct packed {
    logic [3:0] v;
    logic       r;
    way_oup_t   d;
  } rsp_exp_t;
  logic           clk, rst_n;
  way_inp_t [3:0] req;
  logic [3:0]     req_valid, req_last, req_ready, rsp_valid, rsp_ready;
  way_inp_t       way, exp_way;
  logic           way_valid, way_ready, way_rsp_valid, way_rsp_ready;
  way_oup_t       way_rsp, rsp;
  req_exp_t       sq[$];
  rsp_exp_t       rq[$];
  int             n_vec = 0, n_err = 0, step = 0;
  axi_llc_data_way_arb #(.NumReq(4), .MaxBurst(4)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .req_i           (req),
    .req_valid_i     (req_valid),
    .req_last_i      (req_last),
    .req_ready_o     (req_ready),
    .way_o           (way),
    .way_valid_o     (way_valid),
    .way_ready_i     (way_ready),
    .way_rsp_i       (way_rsp),
    .way_rsp_valid_i (way_rsp_valid),
    .way_rsp_ready_o (way_rsp_ready),
    .rsp_o           (rsp),
    .rsp_valid_o     (rsp_valid),
    .rsp_ready_i     (rsp_ready)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic way_inp_t pay(input int i);
    way_inp_t p;
    p.cache_unit = cache_unit_e'(3'(3 - i));
    p.way_ind    = 2'(i);
    p.line_addr  = 8'(8'h40 + i);
    p.blk_offset = 2'(i);
    p.we         = i[0];
    p.data       = 32'hD000_0000 + 32'(i) * 32'h0101_0101;
    p.strb       = 4'(1 << i);
    return p;
  endfunction
  // g < 0: no grant expected on the way this cycle.
  task automatic cyc(input logic [3:0] v, input logic [3:0] l, input logic r, input int g);
    req_exp_t e;
    req_valid = v;
    req_last  = l;
    way_ready = r;
    e.vld = (g >= 0);
    e.gnt = 2'((g >= 0) ? g : 0);
    e.rdy = r ? 4'(1 << e.gnt) : 4'b0;
    sq.push_back(e);
    #1;
    e = sq.pop_front();
    n_vec++;
    assert (way_valid === e.vld) else begin
      n_err++;
      $error("FAIL way_valid step %0d: got %b exp %b", step, way_valid, e.vld);
    end
    if (e.vld) begin
      exp_way            = pay(int'(e.gnt));
      exp_way.cache_unit = cache_unit_e'(3'(e.gnt));
      n_vec++;
      assert (way === exp_way) else begin
        n_err++;
        $error("FAIL way_o step %0d: got %h exp %h", step, way, exp_way);
      end
      n_vec++;
      assert (req_ready === e.rdy) else begin
        n_err++;
        $error("FAIL req_ready step %0d: got %b exp %b", step, req_ready, e.rdy);
      end
    end
    step++;
    @(posedge clk);
    #1;
  endtask
  task automatic rsp_step(input logic vld, input logic [2:0] cu, input logic [3:0] rr,
                          input logic [3:0] ev, input logic er);
    rsp_exp_t e;
    way_rsp.cache_unit = cache_unit_e'(cu);
    way_rsp.data       = 32'hBEEF_0000 + 32'(cu) * 32'h100 + 32'(rr);
    way_rsp_valid      = vld;
    rsp_ready          = rr;
    e.v = ev;
    e.r = er;
    e.d = way_rsp;
    rq.push_back(e);
    #1;
    e = rq.pop_front();
    n_vec++;
    assert (rsp_valid === e.v) else begin
      n_err++;
      $error("FAIL rsp_valid step %0d: got %b exp %b", step, rsp_valid, e.v);
    end
    n_vec++;
    assert (way_rsp_ready === e.r) else begin
      n_err++;
      $error("FAIL way_rsp_ready step %0d: got %b exp %b", step, way_rsp_ready, e.r);
    end
    n_vec++;
    assert (rsp === e.d) else begin
      n_err++;
      $error("FAIL rsp_data step %0d: got %h exp %h", step, rsp, e.d);
    end
    step++;
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst_n         = 1'b0;
    req_valid     = '0;
    req_last      = '0;
    way_ready     = 1'b0;
    way_rsp       = '0;
    way_rsp_valid = 1'b0;
    rsp_ready     = '0;
    for (int i = 0; i < 4; i++) req[i] = pay(i);
    @(posedge clk);
    #1;
    // reset: pointer at 0, nothing ready while way_ready is low
    cyc(4'b1010, 4'b0000, 1'b0, 1);
    cyc(4'b0000, 4'b0000, 1'b0, -1);
    rst_n = 1'b1;
    // 1: single beats rotate 0,1,2,3,0 then drain
    for (int k = 0; k < 5; k++) cyc(4'b1111, 4'b1111, 1'b1, k % 4);
    cyc(4'b1110, 4'b1111, 1'b1, 1);
    cyc(4'b1100, 4'b1111, 1'b1, 2);
    cyc(4'b1000, 4'b1111, 1'b1, 3);
    // 2: req1 four-beat burst holds off req2
    for (int k = 0; k < 3; k++) cyc(4'b0110, 4'b0100, 1'b1, 1);
    cyc(4'b0110, 4'b0110, 1'b1, 1);
    cyc(4'b0100, 4'b0100, 1'b1, 2);
    cyc(4'b1000, 4'b1000, 1'b1, 3);
    // 3: req0 forced off after 4 beats, req3 served, req0 resumes; owner idle keeps lock
    for (int k = 0; k < 4; k++) cyc(4'b1001, 4'b1000, 1'b1, 0);
    cyc(4'b1001, 4'b1000, 1'b1, 3);
    cyc(4'b0001, 4'b0000, 1'b1, 0);
    cyc(4'b0001, 4'b0000, 1'b1, 0);
    cyc(4'b0100, 4'b0000, 1'b1, -1);
    cyc(4'b0101, 4'b0101, 1'b1, 0);
    // 4: way stalls three cycles, request held stable
    for (int k = 0; k < 3; k++) cyc(4'b0100, 4'b0100, 1'b0, 2);
    cyc(4'b0100, 4'b0100, 1'b1, 2);
    // 5: response routing and backpressure
    rsp_step(1'b0, 3'd2, 4'b1111, 4'b0000, 1'b1);
    rsp_step(1'b1, 3'd2, 4'b1011, 4'b0100, 1'b0);
    rsp_step(1'b1, 3'd2, 4'b1011, 4'b0100, 1'b0);
    rsp_step(1'b1, 3'd2, 4'b1111, 4'b0100, 1'b1);
    rsp_step(1'b1, 3'd0, 4'b0001, 4'b0001, 1'b1);
    rsp_step(1'b1, 3'd3, 4'b0111, 4'b1000, 1'b0);
    way_rsp_valid = 1'b0;
    // 6: reset mid-burst of req1 clears lock and pointer
    cyc(4'b0010, 4'b0000, 1'b1, 1);
    cyc(4'b0010, 4'b0000, 1'b1, 1);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    cyc(4'b0011, 4'b0011, 1'b1, 0);
    cyc(4'b0010, 4'b0010, 1'b1, 1);
    cyc(4'b0000, 4'b0000, 1'b0, -1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
